// File: rtl/tiny_controller_pkg.sv
// Purpose : shared opcode, ALU-code, state and field definitions for the tiny processor.
// Latency : n/a (package only).
// Backpressure: n/a; imported by the controller, its decoder, the ALU and the bench.
package tiny_pkg;

  // Opcodes, instruction bits [7:4]. C, D and E are reserved and behave as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation codes driven on alu_op.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Instruction field slices.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPR_MSB = 3;
  localparam int OPR_LSB = 0;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  // ALU opcodes 3..7 map onto ALU codes 0..4 by subtracting 3 from the low bits.
  function automatic logic [2:0] alu_code(input logic [2:0] op_lo);
    return op_lo - 3'd3;
  endfunction

endpackage

// File: rtl/tiny_controller_if.sv
// Purpose : groups the controller <-> ROM/RAM/accumulator/ALU strobes and status lines.
// Latency : n/a (wiring only).
// Backpressure: none; master = controller, slave = datapath side.
interface tiny_controller_if;
  logic [7:0] instr_in;
  logic [3:0] pc_out;
  logic [3:0] ram_addr;
  logic       mem_we;
  logic       mem_oe;
  logic       acc_sel;
  logic       acc_we;
  logic       acc_oe;
  logic       imm_oe;
  logic [2:0] alu_op;
  logic       alu_zero;
  logic       alu_carry;
  logic       zero_flag;
  logic       carry_flag;
  logic       halted;

  modport master (
    input  instr_in, alu_zero, alu_carry,
    output pc_out, ram_addr, mem_we, mem_oe, acc_sel, acc_we, acc_oe, imm_oe,
           alu_op, zero_flag, carry_flag, halted
  );

  modport slave (
    output instr_in, alu_zero, alu_carry,
    input  pc_out, ram_addr, mem_we, mem_oe, acc_sel, acc_we, acc_oe, imm_oe,
           alu_op, zero_flag, carry_flag, halted
  );
endinterface

// File: rtl/tiny_controller_decode.sv
// Purpose : combinational opcode -> RAM/accumulator/immediate strobe and alu_op decode.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; all outputs are 0 unless i_exec is high.
// Ports   : i_exec (EXECUTE and not in reset), i_opcode (IR[7:4]); o_* strobes and ALU code.
module tiny_decode
  import tiny_pkg::*;
(
  input  logic       i_exec,
  input  logic [3:0] i_opcode,
  output logic       o_mem_we,
  output logic       o_mem_oe,
  output logic       o_acc_sel,
  output logic       o_acc_we,
  output logic       o_acc_oe,
  output logic       o_imm_oe,
  output logic [2:0] o_alu_op
);

  always_comb begin
    o_mem_we  = 1'b0;
    o_mem_oe  = 1'b0;
    o_acc_sel = 1'b0;
    o_acc_we  = 1'b0;
    o_acc_oe  = 1'b0;
    o_imm_oe  = 1'b0;
    o_alu_op  = ALU_ADD;
    if (i_exec) begin
      case (i_opcode)
        OP_LDA: begin
          o_mem_oe = 1'b1;
          o_acc_we = 1'b1;
        end
        OP_STA: begin
          o_acc_oe = 1'b1;
          o_mem_we = 1'b1;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          o_mem_oe  = 1'b1;
          o_acc_sel = 1'b1;
          o_acc_we  = 1'b1;
          o_alu_op  = alu_code(i_opcode[2:0]);
        end
        OP_LDI: begin
          o_imm_oe = 1'b1;
          o_acc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tiny_controller.sv
// Purpose : 3-cycle fetch/decode/execute sequencer holding PC, IR and Z/C flags.
// Latency : every instruction takes 3 cycles; HLT parks the machine until rst.
// Backpressure: none; ROM is async, RAM/accumulator accept strobes unconditionally.
// Ports   : clk, rst (sync, active high); ctl (master side of tiny_controller_if);
//           bus (shared tri-state data bus, driven with the immediate during LDI).
module tiny_controller
  import tiny_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic                clk,
  input  logic                rst,
  tiny_controller_if.master   ctl,
  inout  wire  [DATA_W-1:0]   bus
);

  state_t     r_state;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic [3:0] r_ram_addr;
  logic       r_z;
  logic       r_c;

  logic [3:0] w_opcode;
  logic [3:0] w_operand;
  logic       w_exec;
  logic       w_imm_oe;

  assign w_opcode  = r_ir[OPC_MSB:OPC_LSB];
  assign w_operand = r_ir[OPR_MSB:OPR_LSB];
  // Gating with rst kills every strobe in the reset cycle, even mid-EXECUTE.
  assign w_exec    = (r_state == EXECUTE) && !rst;

  tiny_decode u_decode (
    .i_exec    (w_exec),
    .i_opcode  (w_opcode),
    .o_mem_we  (ctl.mem_we),
    .o_mem_oe  (ctl.mem_oe),
    .o_acc_sel (ctl.acc_sel),
    .o_acc_we  (ctl.acc_we),
    .o_acc_oe  (ctl.acc_oe),
    .o_imm_oe  (w_imm_oe),
    .o_alu_op  (ctl.alu_op)
  );

  assign ctl.imm_oe     = w_imm_oe;
  assign bus            = w_imm_oe ? {{(DATA_W-4){1'b0}}, w_operand} : {DATA_W{1'bz}};
  assign ctl.pc_out     = r_pc;
  assign ctl.ram_addr   = r_ram_addr;
  assign ctl.zero_flag  = r_z;
  assign ctl.carry_flag = r_c;
  assign ctl.halted     = (r_state == HALT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 8'h00;
      r_ram_addr <= 4'h0;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir    <= ctl.instr_in;
          r_pc    <= r_pc + 4'd1;
          r_state <= DECODE;
        end
        DECODE: begin
          r_ram_addr <= w_operand;
          r_state    <= EXECUTE;
        end
        EXECUTE: begin
          r_state <= FETCH;
          case (w_opcode)
            OP_ADD, OP_SUB: begin
              r_z <= ctl.alu_zero;
              r_c <= ctl.alu_carry;
            end
            // Logic ops have no meaningful carry; force it clear.
            OP_AND, OP_OR, OP_XOR: begin
              r_z <= ctl.alu_zero;
              r_c <= 1'b0;
            end
            OP_JMP: r_pc <= w_operand;
            OP_JZ:  if (r_z) r_pc <= w_operand;
            OP_JC:  if (r_c) r_pc <= w_operand;
            OP_HLT: r_state <= HALT;
            default: ;
          endcase
        end
        HALT: r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_controller.sv
// Purpose : exercises tiny_controller with a ROM/RAM/accumulator/ALU environment and an ISA-level model.
// Latency : checks every instruction boundary (3 cycles) plus per-cycle bus exclusivity.
// Backpressure: n/a.
module tb_tiny_controller;
  import tiny_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  wire [7:0] bus;
  tiny_controller_if ctl_if ();

  tiny_controller #(.DATA_W(8), .RESET_PC(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl_if),
    .bus (bus)
  );

  // ---------------- environment: ROM, RAM, accumulator, ALU ----------------
  logic [7:0] rom      [16];
  logic [7:0] ram      [16];
  logic [7:0] ram_init [16];
  logic [7:0] acc;
  logic       env_load = 1'b1;
  logic [8:0] alu_res;

  assign ctl_if.instr_in = rom[ctl_if.pc_out];
  assign bus = ctl_if.mem_oe ? ram[ctl_if.ram_addr] : (ctl_if.acc_oe ? acc : 8'hzz);

  // Logic ops report carry=1 so the controller's forced clear is observable.
  always_comb begin
    alu_res = 9'h000;
    case (ctl_if.alu_op)
      ALU_ADD: alu_res = {1'b0, acc} + {1'b0, bus};
      ALU_SUB: alu_res = {1'b0, acc} - {1'b0, bus};
      ALU_AND: alu_res = {1'b1, acc & bus};
      ALU_OR:  alu_res = {1'b1, acc | bus};
      ALU_XOR: alu_res = {1'b1, acc ^ bus};
      default: alu_res = 9'h000;
    endcase
  end
  assign ctl_if.alu_zero  = (alu_res[7:0] == 8'h00);
  assign ctl_if.alu_carry = alu_res[8];

  always @(posedge clk) begin
    if (env_load) begin
      acc <= 8'h00;
      for (int i = 0; i < 16; i++) ram[i] <= ram_init[i];
    end else begin
      if (ctl_if.acc_we) acc <= ctl_if.acc_sel ? alu_res[7:0] : bus;
      if (ctl_if.mem_we) ram[ctl_if.ram_addr] <= bus;
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [3:0] m_pc;
  logic [7:0] m_acc;
  logic [7:0] m_ram [16];
  logic       m_z, m_c, m_halt;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {ctl_if.mem_we, ctl_if.mem_oe, ctl_if.acc_sel, ctl_if.acc_we, ctl_if.acc_oe, ctl_if.imm_oe};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    chk("bus_excl", 32'($onehot0({ctl_if.mem_oe, ctl_if.acc_oe, ctl_if.imm_oe})), 32'd1);
    if (ctl_if.halted) chk("halt_quiet", 32'(strobes()), 32'd0);
  endtask

  task automatic model_reset();
    m_pc = 4'h0; m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 16; i++) m_ram[i] = ram_init[i];
  endtask

  task automatic reset_env();
    env_load = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    env_load = 1'b0;
    model_reset();
  endtask

  task automatic model_step();
    logic [7:0] ins;
    logic [3:0] op, opr;
    logic [8:0] t;
    if (!m_halt) begin
      ins = rom[m_pc];
      op  = ins[7:4];
      opr = ins[3:0];
      m_pc = m_pc + 4'd1;
      case (op)
        4'h1: m_acc = m_ram[opr];
        4'h2: m_ram[opr] = m_acc;
        4'h3: begin t = {1'b0, m_acc} + {1'b0, m_ram[opr]}; m_acc = t[7:0]; m_c = t[8]; m_z = (m_acc == 0); end
        4'h4: begin m_c = (m_acc < m_ram[opr]); m_acc = m_acc - m_ram[opr]; m_z = (m_acc == 0); end
        4'h5: begin m_acc = m_acc & m_ram[opr]; m_c = 1'b0; m_z = (m_acc == 0); end
        4'h6: begin m_acc = m_acc | m_ram[opr]; m_c = 1'b0; m_z = (m_acc == 0); end
        4'h7: begin m_acc = m_acc ^ m_ram[opr]; m_c = 1'b0; m_z = (m_acc == 0); end
        4'h8: m_acc = {4'h0, opr};
        4'h9: m_pc = opr;
        4'hA: if (m_z) m_pc = opr;
        4'hB: if (m_c) m_pc = opr;
        4'hF: m_halt = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic check_state();
    int bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== m_ram[i]) bad++;
    chk("pc",     32'(ctl_if.pc_out),     32'(m_pc));
    chk("acc",    32'(acc),               32'(m_acc));
    chk("zflag",  32'(ctl_if.zero_flag),  32'(m_z));
    chk("cflag",  32'(ctl_if.carry_flag), 32'(m_c));
    chk("halted", 32'(ctl_if.halted),     32'(m_halt));
    chk("ram",    32'(bad),               32'd0);
  endtask

  // Called at the start of a FETCH cycle (or any cycle once halted).
  task automatic run_instrs(input int n);
    for (int k = 0; k < n; k++) begin
      check_state();
      model_step();
      tick(); tick(); tick();
    end
    check_state();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h00;
      ram_init[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    // --- LDI 5: reset state, strobe timing, immediate on bus ---
    clear_mem();
    rom[0] = 8'h85;
    reset_env();
    chk("rst_pc",      32'(ctl_if.pc_out),     32'd0);
    chk("rst_strobes", 32'(strobes()),         32'd0);
    chk("rst_halted",  32'(ctl_if.halted),     32'd0);
    chk("rst_z",       32'(ctl_if.zero_flag),  32'd0);
    chk("rst_c",       32'(ctl_if.carry_flag), 32'd0);
    chk("rst_ir",      32'(dut.r_ir),          32'd0);
    chk("rst_state",   32'(dut.r_state),       32'(FETCH));
    chk("rst_aluop",   32'(ctl_if.alu_op),     32'd0);
    chk("rst_raddr",   32'(ctl_if.ram_addr),   32'd0);
    tick();
    chk("ldi_c2_strobes", 32'(strobes()), 32'd0);
    tick();
    chk("ldi_c3_strobes", 32'(strobes()), 32'b000101);
    chk("ldi_c3_bus",     32'(bus),       32'h05);
    tick();
    chk("ldi_pc", 32'(ctl_if.pc_out), 32'd1);
    chk("ldi_acc", 32'(acc), 32'h05);

    // --- LDI 3; STA 2; ADD 2; HLT ---
    clear_mem();
    rom[0] = 8'h83; rom[1] = 8'h22; rom[2] = 8'h32; rom[3] = 8'hF0;
    reset_env();
    run_instrs(4);
    chk("prog_acc",  32'(acc),               32'h06);
    chk("prog_ram2", 32'(ram[2]),            32'h03);
    chk("prog_z",    32'(ctl_if.zero_flag),  32'd0);
    chk("prog_c",    32'(ctl_if.carry_flag), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", 32'(ctl_if.halted), 32'd1);
      chk("halt_pc",   32'(ctl_if.pc_out), 32'd4);
    end

    // --- LDI 1; SUB 4; JZ 7, taken and not taken ---
    clear_mem();
    rom[0] = 8'h81; rom[1] = 8'h44; rom[2] = 8'hA7;
    ram_init[4] = 8'h01;
    reset_env();
    run_instrs(3);
    chk("jz_taken_pc", 32'(ctl_if.pc_out), 32'd7);
    ram_init[4] = 8'h02;
    reset_env();
    run_instrs(3);
    chk("jz_fall_pc", 32'(ctl_if.pc_out), 32'd3);
    chk("sub_borrow", 32'(ctl_if.carry_flag), 32'd1);

    // --- JMP 15 then NOP at 15: PC wraps to 0 ---
    clear_mem();
    rom[0] = 8'h9F; rom[15] = 8'h00;
    reset_env();
    run_instrs(1);
    chk("jmp_pc", 32'(ctl_if.pc_out), 32'd15);
    run_instrs(1);
    chk("wrap_pc", 32'(ctl_if.pc_out), 32'd0);
    run_instrs(1);
    chk("refetch_pc", 32'(ctl_if.pc_out), 32'd15);

    // --- reset asserted during EXECUTE of STA ---
    clear_mem();
    rom[0] = 8'h83; rom[1] = 8'h22;
    ram_init[2] = 8'hAA;
    reset_env();
    run_instrs(1);
    tick(); tick();
    chk("sta_exec_we", 32'(ctl_if.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("sta_rst_we", 32'(ctl_if.mem_we), 32'd0);
    chk("sta_rst_oe", 32'(ctl_if.acc_oe), 32'd0);
    tick();
    rst = 1'b0;
    chk("sta_rst_ram",   32'(ram[2]),         32'hAA);
    chk("sta_rst_pc",    32'(ctl_if.pc_out),  32'd0);
    chk("sta_rst_ir",    32'(dut.r_ir),       32'd0);
    chk("sta_rst_state", 32'(dut.r_state),    32'(FETCH));

    // --- reserved opcode C3 keeps flags, advances PC ---
    clear_mem();
    rom[0] = 8'h8F; rom[1] = 8'h31; rom[2] = 8'hC3;
    ram_init[1] = 8'hF1;
    reset_env();
    run_instrs(2);
    tick(); tick();
    chk("rsv_strobes", 32'(strobes()), 32'd0);
    tick();
    chk("rsv_z",   32'(ctl_if.zero_flag),  32'd1);
    chk("rsv_c",   32'(ctl_if.carry_flag), 32'd1);
    chk("rsv_pc",  32'(ctl_if.pc_out),     32'd3);
    chk("rsv_acc", 32'(acc),               32'h00);

    // --- random programs against the ISA model ---
    for (int p = 0; p < 12; p++) begin
      clear_mem();
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      reset_env();
      run_instrs(24);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tiny_controller.md
Name: tiny_controller

Overview:
Fetch/decode/execute sequencer for the tiny processor; sits directly upstream of the accumulator and drives its acc_sel, write_en and output_en strobes. It also drives the data-RAM strobes, the ALU opcode and immediate values onto the shared 8-bit bus. It holds the PC, the instruction register (IR) and the zero/carry flags. Every instruction takes exactly 3 cycles, except HLT, which parks the machine.

Parameters:
DATA_W, 8, shared bus / accumulator width; immediates are zero-extended to this width.
RESET_PC, 4'h0, PC value loaded on reset.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
instr_in  input  8  instruction from async program ROM at pc_out; opcode is [7:4], operand is [3:0]
pc_out  output  4  program counter
ram_addr  output  4  data-RAM address; registered copy of the operand
mem_we  output  1  data-RAM write strobe; RAM samples the bus
mem_oe  output  1  data-RAM drives the bus
acc_sel  output  1  accumulator source select: 1 = ALU result, 0 = bus
acc_we  output  1  accumulator write enable
acc_oe  output  1  accumulator drives the bus
bus  inout  DATA_W  shared data bus; the controller drives the zero-extended immediate when imm_oe=1, otherwise high-Z
alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
alu_zero  input  1  ALU zero result, combinational
alu_carry  input  1  ALU carry/borrow out, combinational
zero_flag  output  1  registered Z flag
carry_flag  output  1  registered C flag
halted  output  1  high in HALT state

Behaviour:
- Reset (rst=1 at an edge):
  - state <= FETCH, pc <= RESET_PC, ir <= 8'h00, ram_addr <= 0, Z <= 0, C <= 0.
  - All strobes (mem_we, mem_oe, acc_we, acc_oe, imm_oe, acc_sel) are combinationally forced to 0 while rst=1, including mid-instruction.
  - alu_op = 0, halted = 0.
- States: FETCH -> DECODE -> EXECUTE -> FETCH. HALT is terminal; only rst leaves it.
- FETCH: ir <= instr_in; pc <= pc+1, wrapping 15 -> 0. No strobes asserted.
- DECODE: ram_addr <= ir[3:0]. No strobes asserted.
- EXECUTE: strobes are a combinational decode of (state==EXECUTE, ir[7:4]). The accumulator/RAM write occurs on the edge ending EXECUTE.
  - 0 NOP: nothing.
  - 1 LDA: mem_oe=1, acc_sel=0, acc_we=1.
  - 2 STA: acc_oe=1, mem_we=1.
  - 3..7 ADD/SUB/AND/OR/XOR: mem_oe=1, alu_op=ir[6:4]-3, acc_sel=1, acc_we=1. Also Z <= alu_zero and C <= alu_carry. For AND/OR/XOR, C <= 0.
  - 8 LDI: imm_oe=1 with bus={4'h0,ir[3:0]}, acc_sel=0, acc_we=1.
  - 9 JMP: pc <= ir[3:0].
  - A JZ: pc <= ir[3:0] if Z=1, else unchanged.
  - B JC: pc <= ir[3:0] if C=1, else unchanged.
  - F HLT: next state HALT.
  - C, D, E are reserved and execute as NOP.
- Bus exclusivity: at most one of mem_oe, acc_oe, imm_oe is high in any cycle; the bench asserts this.
- Flags change only on ALU opcodes.
- A jump whose target equals the current pc is legal and loops forever.
- HALT: all strobes 0, pc/ir/flags frozen, halted=1.
- Throughput: one instruction per 3 cycles. The new accumulator value is visible on the first FETCH cycle after EXECUTE.

Decomposition:
- Shared package (tiny_pkg): opcode constants OP_NOP..OP_HLT, ALU op codes ALU_ADD..ALU_XOR, state encoding typedef/localparams FETCH/DECODE/EXECUTE/HALT, and the instruction field slice constants. The ALU and the bench use the same package.
- One natural sub-module, tiny_decode: purely combinational opcode -> strobe/alu_op decode. The top keeps the FSM, PC, IR and flags.

Test Plan:
- Reset then ROM[0]=8'h85 (LDI 5): acc_we and imm_oe high, bus=8'h05 in cycle 3 (EXECUTE); pc_out=1 afterwards; no other strobe high in cycles 1-3.
- Program LDI 3; STA 2; ADD 2; HLT: RAM[2]=3 after cycle 6; accumulator=6 after cycle 9; Z=0, C=0; halted=1 from cycle 13 and stays high for 20 further cycles.
- LDI 1; SUB with RAM[4]=1 giving Z=1; JZ 7: pc_out=7 at the next FETCH. Repeat with a nonzero result: JZ falls through to pc=3.
- JMP 15 then a NOP at address 15: pc wraps 15 -> 0 and the next fetch is from address 0.
- Assert rst during the EXECUTE of STA: mem_we=0 in that same cycle, RAM unchanged; after release, pc_out=0, ir=0, state FETCH.
- Opcode 8'hC3 (reserved): no strobes, flags unchanged, pc advances by 1.
